// File: rtl/ex_mem_elastic_reg.sv
// Elastic EX->MEM pipeline register with a 2-entry skid buffer, flush and a stall-cycle counter.
// Latency: 1 cycle from input transfer to out_valid; one entry per cycle while out_ready stays high.
// Backpressure: the skid entry absorbs one extra instruction; in_ready (a flop) drops only while skid is full.
//
// Ports:
//   clk, rst_n (synchronous, active-low), flush (kills held and incoming entries)
//   in_valid/in_ready + *_E fields   : EX-side handshake and instruction payload
//   out_valid/out_ready + *_M fields : MEM-side handshake and head-entry payload
//   clr_cnt/stall_cnt                : saturating count of out_valid && !out_ready cycles
module ex_mem_elastic_reg #(
  parameter int WIDTH       = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   RegWrite_E,
  input  logic [1:0]             ResultSrc_E,
  input  logic                   MemWrite_E,
  input  logic [WIDTH-1:0]       ALUResult_E,
  input  logic [WIDTH-1:0]       WriteData_E,
  input  logic [WIDTH-1:0]       PCPlus4_E,
  input  logic [REG_ADDR_W-1:0]  Rd_E,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   RegWrite_M,
  output logic [1:0]             ResultSrc_M,
  output logic                   MemWrite_M,
  output logic [WIDTH-1:0]       ALUResult_M,
  output logic [WIDTH-1:0]       WriteData_M,
  output logic [WIDTH-1:0]       PCPlus4_M,
  output logic [REG_ADDR_W-1:0]  Rd_M,
  input  logic                   clr_cnt,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic                  reg_write;
    logic [1:0]            result_src;
    logic                  mem_write;
    logic [WIDTH-1:0]      alu_result;
    logic [WIDTH-1:0]      write_data;
    logic [WIDTH-1:0]      pc_plus4;
    logic [REG_ADDR_W-1:0] rd;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [STALL_CNT_W-1:0] CNT_MAX = '1;

  state_t state;
  entry_t main_q;
  entry_t skid_q;
  entry_t in_ent;
  logic   in_xfer;
  logic   out_xfer;

  assign in_ent = {RegWrite_E, ResultSrc_E, MemWrite_E, ALUResult_E,
                   WriteData_E, PCPlus4_E, Rd_E};

  assign out_valid = (state != EMPTY);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  // Payload is only captured on an input transfer, so garbage on the _E
  // inputs while in_valid=0 never reaches the stored entries.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
      main_q   <= '0;
      skid_q   <= '0;
    end else if (flush) begin
      // Any simultaneous output transfer already happened; the incoming
      // entry is simply not captured. Data fields keep their old values.
      state    <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            main_q <= in_ent;
            state  <= ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_q <= in_ent;
          end else if (in_xfer) begin
            skid_q   <= in_ent;
            state    <= TWO;
            in_ready <= 1'b0;
          end else if (out_xfer) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so only the output side can move.
          if (out_xfer) begin
            main_q   <= skid_q;
            state    <= ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state    <= EMPTY;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

  // Write enables are masked by out_valid so a bubble can never write.
  assign RegWrite_M  = main_q.reg_write & out_valid;
  assign MemWrite_M  = main_q.mem_write & out_valid;
  assign ResultSrc_M = main_q.result_src;
  assign ALUResult_M = main_q.alu_result;
  assign WriteData_M = main_q.write_data;
  assign PCPlus4_M   = main_q.pc_plus4;
  assign Rd_M        = main_q.rd;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (clr_cnt) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ex_mem_elastic_reg.sv
module tb_ex_mem_elastic_reg;

  typedef struct packed {
    logic        rw;
    logic [1:0]  rs;
    logic        mw;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] pc;
    logic [4:0]  rd;
  } ent_t;

  typedef struct {
    logic        iv;
    logic        ordy;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        exp_ov;
    logic        exp_ir;
    logic [31:0] exp_alu;
    logic [3:0]  exp_cnt;
  } vec_t;

  logic        clk;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, clr_cnt;
  logic        RegWrite_E, MemWrite_E, RegWrite_M, MemWrite_M;
  logic [1:0]  ResultSrc_E, ResultSrc_M;
  logic [31:0] ALUResult_E, WriteData_E, PCPlus4_E;
  logic [31:0] ALUResult_M, WriteData_M, PCPlus4_M;
  logic [4:0]  Rd_E, Rd_M;
  logic [3:0]  stall_cnt;

  ex_mem_elastic_reg #(.WIDTH(32), .REG_ADDR_W(5), .STALL_CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .RegWrite_E(RegWrite_E), .ResultSrc_E(ResultSrc_E), .MemWrite_E(MemWrite_E),
    .ALUResult_E(ALUResult_E), .WriteData_E(WriteData_E), .PCPlus4_E(PCPlus4_E), .Rd_E(Rd_E),
    .out_valid(out_valid), .out_ready(out_ready),
    .RegWrite_M(RegWrite_M), .ResultSrc_M(ResultSrc_M), .MemWrite_M(MemWrite_M),
    .ALUResult_M(ALUResult_M), .WriteData_M(WriteData_M), .PCPlus4_M(PCPlus4_M), .Rd_M(Rd_M),
    .clr_cnt(clr_cnt), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int c0_seen = 0;

  // Reference model: a FIFO of at most two entries plus the last head shown.
  ent_t mq[$];
  ent_t hold;
  int   mcnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t mk(input logic [31:0] alu, input logic [4:0] rd,
                              input logic rw, input logic mw);
    ent_t e;
    e.rw  = rw;
    e.rs  = alu[1:0];
    e.mw  = mw;
    e.alu = alu;
    e.wd  = alu ^ 32'h5A5A_0000;
    e.pc  = alu + 32'd4;
    e.rd  = rd;
    return e;
  endfunction

  task automatic check_model();
    logic busy;
    busy = (mq.size() > 0);
    chk("out_valid", {31'd0, out_valid}, {31'd0, busy});
    chk("in_ready", {31'd0, in_ready}, {31'd0, mq.size() < 2});
    chk("RegWrite_M", {31'd0, RegWrite_M}, {31'd0, busy & hold.rw});
    chk("MemWrite_M", {31'd0, MemWrite_M}, {31'd0, busy & hold.mw});
    chk("ResultSrc_M", {30'd0, ResultSrc_M}, {30'd0, hold.rs});
    chk("ALUResult_M", ALUResult_M, hold.alu);
    chk("WriteData_M", WriteData_M, hold.wd);
    chk("PCPlus4_M", PCPlus4_M, hold.pc);
    chk("Rd_M", {27'd0, Rd_M}, {27'd0, hold.rd});
    chk("stall_cnt", {28'd0, stall_cnt}, mcnt);
  endtask

  // One clock: drive inputs, advance the model with the pre-edge view, compare.
  task automatic step(input logic r, input logic f, input logic iv, input logic ordy,
                      input logic c, input ent_t e);
    ent_t drv;
    logic busy, ox, ix;
    drv = iv ? e : ent_t'({$urandom, $urandom, $urandom, $urandom});
    rst_n = r; flush = f; in_valid = iv; out_ready = ordy; clr_cnt = c;
    RegWrite_E = drv.rw; ResultSrc_E = drv.rs; MemWrite_E = drv.mw;
    ALUResult_E = drv.alu; WriteData_E = drv.wd; PCPlus4_E = drv.pc; Rd_E = drv.rd;
    #1;
    if (out_valid && out_ready && ALUResult_M == 32'hC0) c0_seen++;
    @(posedge clk);
    busy = (mq.size() > 0);
    if (!r) begin
      mq.delete();
      hold = '0;
      mcnt = 0;
    end else begin
      if (c) mcnt = 0;
      else if (busy && !ordy && mcnt < 15) mcnt++;
      if (f) begin
        mq.delete();
      end else begin
        ox = busy && ordy;
        ix = iv && (mq.size() < 2);
        if (ox) void'(mq.pop_front());
        if (ix) mq.push_back(e);
      end
      if (mq.size() > 0) hold = mq[0];
    end
    #1;
    check_model();
  endtask

  vec_t tbl[15];
  ent_t nul;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    nul = '0;
    hold = '0;
    mcnt = 0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0;
    RegWrite_E = 1'b0; ResultSrc_E = 2'd0; MemWrite_E = 1'b0;
    ALUResult_E = '0; WriteData_E = '0; PCPlus4_E = '0; Rd_E = '0;

    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, nul);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, nul);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_alu", ALUResult_M, 32'd0);

    // Streaming then back-pressure, as a vector table.
    for (int i = 0; i < 8; i++)
      tbl[i] = '{1'b1, 1'b1, 32'h10 + i, 5'(i + 1), 1'b1, 1'b1, 32'h10 + i, 4'd0};
    tbl[8]  = '{1'b0, 1'b1, 32'h0,  5'd0, 1'b0, 1'b1, 32'h17, 4'd0};
    tbl[9]  = '{1'b1, 1'b0, 32'hA0, 5'd9, 1'b1, 1'b1, 32'hA0, 4'd0};
    tbl[10] = '{1'b1, 1'b0, 32'hA1, 5'd10, 1'b1, 1'b0, 32'hA0, 4'd1};
    tbl[11] = '{1'b1, 1'b0, 32'hA2, 5'd11, 1'b1, 1'b0, 32'hA0, 4'd2};
    tbl[12] = '{1'b1, 1'b1, 32'hA2, 5'd11, 1'b1, 1'b1, 32'hA1, 4'd2};
    tbl[13] = '{1'b1, 1'b1, 32'hA2, 5'd11, 1'b1, 1'b1, 32'hA2, 4'd2};
    tbl[14] = '{1'b0, 1'b1, 32'h0,  5'd0, 1'b0, 1'b1, 32'hA2, 4'd2};
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 1'b0, tbl[i].iv, tbl[i].ordy, 1'b0, mk(tbl[i].alu, tbl[i].rd, 1'b1, 1'b0));
      chk($sformatf("tbl%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].exp_ov});
      chk($sformatf("tbl%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].exp_ir});
      chk($sformatf("tbl%0d_alu", i), ALUResult_M, tbl[i].exp_alu);
      chk($sformatf("tbl%0d_stall_cnt", i), {28'd0, stall_cnt}, {28'd0, tbl[i].exp_cnt});
    end

    // Flush while two entries are held, with an incoming 0xB2.
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, mk(32'hB0, 5'd1, 1'b1, 1'b1));
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, mk(32'hB1, 5'd2, 1'b1, 1'b1));
    chk("two_in_ready", {31'd0, in_ready}, 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, mk(32'hB2, 5'd3, 1'b1, 1'b1));
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_regwrite", {31'd0, RegWrite_M}, 32'd0);
    chk("flush_memwrite", {31'd0, MemWrite_M}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, nul);
      chk("no_B2", {31'd0, ALUResult_M == 32'hB2}, 32'd0);
    end

    // Flush coinciding with the output transfer of 0xC0.
    c0_seen = 0;
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, mk(32'hC0, 5'd4, 1'b0, 1'b1));
    chk("c0_memwrite", {31'd0, MemWrite_M}, 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, nul);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, nul);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, nul);
    chk("c0_once", c0_seen, 32'd1);
    chk("c0_empty", {31'd0, out_valid}, 32'd0);

    // Counter saturation and clear-during-stall.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, nul);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, mk(32'hE0, 5'd5, 1'b1, 1'b0));
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, nul);
    chk("cnt_saturate", {28'd0, stall_cnt}, 32'd15);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, nul);
    chk("cnt_clear", {28'd0, stall_cnt}, 32'd0);

    // Reset in the middle of operation while in TWO.
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, mk(32'hE1, 5'd6, 1'b1, 1'b1));
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, mk(32'hE2, 5'd7, 1'b1, 1'b1));
    chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mrst_alu", ALUResult_M, 32'd0);
    chk("mrst_rd", {27'd0, Rd_M}, 32'd0);
    chk("mrst_cnt", {28'd0, stall_cnt}, 32'd0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, mk(32'hD0, 5'd8, 1'b1, 1'b0));
    chk("d0_out_valid", {31'd0, out_valid}, 32'd1);
    chk("d0_alu", ALUResult_M, 32'hD0);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 63) != 0), ($urandom_range(0, 9) == 0),
           1'($urandom), 1'($urandom), ($urandom_range(0, 19) == 0),
           mk($urandom, 5'($urandom), 1'($urandom), 1'($urandom)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_mem_elastic_reg.md
Name: ex_mem_elastic_reg

Overview:
- Parametrised, elastic EX->MEM pipeline register. Generational successor to the fixed EX/MEM latch.
- Carries ALU result, store data, PC+4, rd and MEM/WB control fields across a valid/ready handshake.
- Contains a 2-entry skid buffer, so back-pressure from MEM (e.g. a multi-cycle data memory) never drops or duplicates an instruction.
- Adds a synchronous flush for branch/jump kill, bubble-safe control zeroing, and a saturating stall-cycle counter for performance monitoring.

Parameters:
- WIDTH, 32: width of ALU result, write data and PC+4 fields.
- REG_ADDR_W, 5: destination register index width.
- STALL_CNT_W, 16: width of stall-cycle counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- flush  in  1  kill all held and incoming entries this cycle.
- in_valid  in  1  EX presents a valid instruction.
- in_ready  out  1  register can accept; registered output.
- RegWrite_E  in  1  register-file write enable.
- ResultSrc_E  in  2  writeback mux select.
- MemWrite_E  in  1  data memory write enable.
- ALUResult_E  in  WIDTH  ALU output / memory address.
- WriteData_E  in  WIDTH  store data.
- PCPlus4_E  in  WIDTH  PC+4 for JAL/JALR writeback.
- Rd_E  in  REG_ADDR_W  destination register.
- out_valid  out  1  MEM-side entry valid.
- out_ready  in  1  MEM accepts this cycle.
- RegWrite_M, ResultSrc_M, MemWrite_M, ALUResult_M, WriteData_M, PCPlus4_M, Rd_M  out  as _E counterparts  head entry fields.
- clr_cnt  in  1  clear stall counter.
- stall_cnt  out  STALL_CNT_W  cycles with out_valid=1 and out_ready=0.

Behaviour:
- Handshakes:
  - Input transfer when in_valid && in_ready at the edge.
  - Output transfer when out_valid && out_ready at the edge.
- Storage: main (head) and skid entries. Outputs are driven directly from main (no combinational path from inputs to outputs). in_ready is a flop equal to "skid empty".
- States:
  - EMPTY: main invalid, skid invalid.
  - ONE: main valid, skid invalid.
  - TWO: main valid, skid valid.
- Transitions when flush=0:
  - EMPTY + in xfer -> ONE (main <= in).
  - ONE + in xfer + out xfer -> ONE (main <= in).
  - ONE + in xfer, no out xfer -> TWO (skid <= in).
  - ONE + out xfer, no in xfer -> EMPTY.
  - ONE, neither -> ONE, hold.
  - TWO (in_ready=0) + out xfer -> ONE (main <= skid).
  - TWO, no out xfer -> TWO, hold.
- Ordering: strict FIFO; no entry is lost or duplicated.
- Latency: 1 cycle from input transfer to out_valid. With out_ready held at 1, throughput is one entry per cycle and state never leaves EMPTY/ONE.
- Flush (priority over everything except reset):
  - Next state is EMPTY.
  - A simultaneous input transfer is discarded.
  - A simultaneous output transfer counts as completed: MEM sampled it.
  - in_ready is 1 the following cycle.
- Bubble zeroing: while out_valid=0, RegWrite_M=0 and MemWrite_M=0, so MEM/WB may ignore out_valid safely. Data fields hold their last values.
- Stall counter:
  - Increments each cycle out_valid && !out_ready.
  - Saturates at 2^STALL_CNT_W-1.
  - clr_cnt forces 0 and has priority over increment.
  - flush does not affect it.
- Reset (rst_n=0 at edge):
  - State EMPTY; out_valid=0; in_ready=1.
  - All _M outputs 0; stall_cnt=0.
  - Applies mid-operation: held entries are dropped, and no transfer is accepted in the reset cycle.
- Unknown/X on data inputs while in_valid=0 must not propagate to control outputs.

Test Plan:
- Streaming: reset, then 8 back-to-back entries (ALUResult_E=0x10..0x17, Rd_E=1..8), out_ready=1 -> out_valid rises 1 cycle after first input; outputs 0x10..0x17 in order, one per cycle; in_ready stays 1; stall_cnt=0.
- Back-pressure: send 0xA0, 0xA1, 0xA2 with out_ready=0 -> state TWO after 0xA1; in_ready=0 holds 0xA2. Raise out_ready -> 0xA0, 0xA1, 0xA2 delivered in order, none lost; stall_cnt equals the number of out_valid&&!out_ready cycles.
- Flush in TWO with in_valid=1 (0xB2) and out_ready=0 -> next cycle out_valid=0, RegWrite_M=0, MemWrite_M=0, in_ready=1; 0xB2 never appears.
- Flush coinciding with an output transfer of 0xC0 (MemWrite_E=1) -> 0xC0 is accepted by MEM exactly once; queue empty afterwards.
- Counter: STALL_CNT_W=4, out_ready=0 with out_valid=1 for 20 cycles -> stall_cnt saturates at 15. Pulse clr_cnt together with a stall cycle -> stall_cnt=0.
- Mid-operation reset: state TWO, rst_n=0 for 1 cycle -> all outputs 0, in_ready=1 afterwards; next input 0xD0 appears after 1 cycle.
